dsp_post_add_p_stage: RTL
=========================

Name: dsp_post_add_p_stage

Overview:
- Output end of the DSP48A1-style slice: the post-adder/subtractor, the P register and the CARRYOUT register.
- Consumes operands already registered by the input stage.
- Produces P, PCOUT and CARRYOUT/CARRYOUTF.
- Supports accumulate (P feedback) and cascade (PCIN) operation selected per cycle by OPMODE-style controls.

Parameters:
- WIDTHP, 48, width of X/Z operands, P and PCOUT
- PREG, 1, 1 = P registered (1-cycle latency); 0 = P combinational
- CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high; clears P and CARRYOUT registers
- cep  input  1  clock enable for P and CARRYOUT registers
- x_in  input  WIDTHP  X operand (multiplier result or D:A:B concatenation, already muxed upstream)
- c_in  input  WIDTHP  C operand
- pcin  input  WIDTHP  cascade input from previous slice
- z_sel  input  2  Z mux: 00 = zero, 01 = pcin, 10 = P feedback, 11 = c_in
- sub  input  1  0 = Z+(X+CIN), 1 = Z-(X+CIN)
- carryin  input  1  carry-in CIN, already registered upstream
- p_out  output  WIDTHP  P result
- pcout  output  WIDTHP  cascade output, always equal to p_out
- carryout  output  1  carry/borrow bit
- carryoutf  output  1  fabric copy of carryout, identical value

Behaviour:
- Arithmetic uses WIDTHP+1 unsigned bits. Operands are zero-extended.
- sub=0: r = Z + X + CIN.
- sub=1: r = Z - (X + CIN).
- Result mapping: p_next = r[WIDTHP-1:0]; co_next = r[WIDTHP].
- For subtract, co_next=1 indicates a borrow (wrap below zero).
- Wrap-around is modulo 2^WIDTHP. No saturation unless the optional feature is enabled.
- P feedback source (z_sel=10) is always the internal P register.
  - With PREG=0 the register is not built; z_sel=10 then selects zero.
- PREG=1:
  - Posedge clk with cep=1: P <= p_next.
  - cep=0: P holds.
  - Latency is 1 cycle from operands to p_out.
- PREG=0: p_out = p_next combinationally; latency 0.
- CARRYOUTREG=1: carryout register loads co_next under cep, with the same timing as P. CARRYOUTREG=0: carryout = co_next combinationally.
- Reset:
  - rst=1 clears P and the carryout register to 0 immediately, independent of clk.
  - p_out, pcout, carryout and carryoutf all read 0 while rst=1 in registered modes.
  - rst takes priority over cep.
  - Reset mid-accumulation discards the accumulated value; the first post-reset accumulate uses feedback 0.
- Simultaneous events:
  - Accumulate (z_sel=10) with cep=1 uses the pre-edge P value and loads the new sum at the same edge.
  - With cep=0 the sum is computed but not captured.
- Unknown z_sel (X/Z values) propagates X; no illegal states exist.

Optional Feature:
- Macro: DSP_P_OVF_STICKY_EN
- Defined:
  - Adds output ovf_sticky (1 bit), a register reset to 0 by rst.
  - Sets at a cep=1 edge when co_next=1 (carry out or borrow).
  - Stays set until rst or until a cep=1 edge with z_sel != 10 (start of a new accumulation), which loads co_next.
- Not defined: port and register are absent; no other behaviour changes.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle with P=0x1234 -> p_out, pcout and carryout all 0 before the next clk edge.
- Add path (PREG=1): z_sel=11, c_in=5, x_in=3, carryin=1, sub=0, cep=1 -> p_out=9 one cycle later, carryout=0.
- Accumulate: load P=10 via c_in, then z_sel=10, x_in=7, cep=1 for 3 cycles -> P=17, 24, 31. Drop cep for 2 cycles -> P holds 31.
- Wrap and carry: z_sel=11, c_in=0xFFFF_FFFF_FFFF, x_in=1, carryin=0 -> p_out=0, carryout=1, carryoutf=1.
- Borrow: sub=1, z_sel=01, pcin=2, x_in=3, carryin=0 -> p_out=0xFFFF_FFFF_FFFF, carryout=1. With DSP_P_OVF_STICKY_EN, ovf_sticky=1 and stays 1 through subsequent z_sel=10 accumulates with no carry.
- PREG=0, CARRYOUTREG=0 build: z_sel=01, pcin=100, x_in=20, carryin=0, sub=0 -> p_out=120 in the same cycle. z_sel=10 -> feedback treated as 0, p_out=20.

Source files
------------

// File: rtl/dsp_post_add_p_stage.sv
// Post-adder/subtractor, P register and CARRYOUT register of a DSP48A1-style slice.
// Optional sticky overflow flag enabled by defining DSP_P_OVF_STICKY_EN.
module dsp_post_add_p_stage #(
  parameter int WIDTHP      = 48,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cep,
  input  logic [WIDTHP-1:0] x_in,
  input  logic [WIDTHP-1:0] c_in,
  input  logic [WIDTHP-1:0] pcin,
  input  logic [1:0]        z_sel,
  input  logic              sub,
  input  logic              carryin,
  output logic [WIDTHP-1:0] p_out,
  output logic [WIDTHP-1:0] pcout,
  output logic              carryout,
`ifdef DSP_P_OVF_STICKY_EN
  output logic              ovf_sticky,
`endif
  output logic              carryoutf
);

  logic [WIDTHP-1:0] p_q;
  logic [WIDTHP-1:0] z_mux;
  logic [WIDTHP:0]   x_ext;
  logic [WIDTHP:0]   r;
  logic [WIDTHP-1:0] p_next;
  logic              co_next;

  // p_q is tied to zero when PREG=0, so z_sel=10 then selects zero.
  // NOTE: every output of a combinational block is assigned on all paths to avoid inferred latches.
  always_comb begin
    z_mux = '0;
    case (z_sel)
      2'b00:   z_mux = '0;
      2'b01:   z_mux = pcin;
      2'b10:   z_mux = p_q;
      2'b11:   z_mux = c_in;
      default: z_mux = 'x;
    endcase
  end

  // One extra bit holds the carry (add) or the borrow (subtract).
  always_comb begin
    x_ext = {1'b0, x_in} + {{WIDTHP{1'b0}}, carryin};
    r     = sub ? ({1'b0, z_mux} - x_ext) : ({1'b0, z_mux} + x_ext);
  end

  assign p_next  = r[WIDTHP-1:0];
  assign co_next = r[WIDTHP];

  generate
    if (PREG == 1) begin : g_preg
      // NOTE: sequential state uses non-blocking assignments; rst is asynchronous and wins over cep.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      p_q <= '0;
        else if (cep) p_q <= p_next;
      end
      assign p_out = p_q;
    end else begin : g_pcomb
      assign p_q   = '0;
      assign p_out = p_next;
    end

    if (CARRYOUTREG == 1) begin : g_coreg
      logic co_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      co_q <= 1'b0;
        else if (cep) co_q <= co_next;
      end
      assign carryout = co_q;
    end else begin : g_cocomb
      assign carryout = co_next;
    end
  endgenerate

  assign pcout     = p_out;
  assign carryoutf = carryout;

`ifdef DSP_P_OVF_STICKY_EN
  // Accumulating edges OR in new carries; any other load starts a fresh flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (cep) begin
      if (z_sel == 2'b10) ovf_sticky <= ovf_sticky | co_next;
      else                ovf_sticky <= co_next;
    end
  end
`endif

endmodule
